vx_fetch: RTL and testbench
===========================

VX_FETCH -- requirements
Module: VX_fetch

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: warps per core.
REQ-002 SHALL have parameter NUM_THREADS, default 4: threads per warp.
REQ-003 SHALL have parameter PC_BITS, default 30: word PC width.
REQ-004 SHALL have parameter UUID_WIDTH, default 1: instruction uuid width.
REQ-005 SHALL have parameter MAX_PENDING, default 4 (range 1..NUM_WARPS): maximum outstanding icache requests.
REQ-006 SHALL define NW_WIDTH as max(1, clog2(NUM_WARPS)) for all wid/tag ports.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high.
REQ-009 SHALL have ports sched_valid (in, 1), sched_ready (out, 1), sched_tmask (in, NUM_THREADS), sched_pc (in, PC_BITS), sched_wid (in, NW_WIDTH), sched_uuid (in, UUID_WIDTH): warp schedule input.
REQ-010 SHALL have ports icache_req_valid (out, 1), icache_req_ready (in, 1), icache_req_addr (out, PC_BITS), icache_req_tag (out, NW_WIDTH): instruction cache request.
REQ-011 SHALL have ports icache_rsp_valid (in, 1), icache_rsp_ready (out, 1), icache_rsp_data (in, 32), icache_rsp_tag (in, NW_WIDTH): instruction cache response, possibly out of order.
REQ-012 SHALL have ports fetch_valid (out, 1), fetch_ready (in, 1), fetch_wid (out, NW_WIDTH), fetch_tmask (out, NUM_THREADS), fetch_pc (out, PC_BITS), fetch_uuid (out, UUID_WIDTH), fetch_instr (out, 32): output to decode.
REQ-013 SHALL have port busy, output, 1: requests in flight or output held.
REQ-014 SHALL have port tag_error, output, 1: sticky protocol-error flag.

Function
REQ-015 SHALL keep a per-warp pending bit plus a metadata table (tmask, pc, uuid) indexed by wid; icache tag = wid.
REQ-016 SHALL keep an outstanding counter of width clog2(MAX_PENDING+1).
REQ-017 SHALL drive icache_req_valid = sched_valid & ~pending[sched_wid] & (outstanding < MAX_PENDING), combinationally.
REQ-018 SHALL drive sched_ready = icache_req_ready & ~pending[sched_wid] & (outstanding < MAX_PENDING).
REQ-019 SHALL drive icache_req_addr = sched_pc and icache_req_tag = sched_wid.
REQ-020 On request fire, SHALL set pending[sched_wid] and write its tmask/pc/uuid into the table at the next edge.
REQ-021 SHALL hold the fetch output in one register stage: icache_rsp_ready = ~fetch_valid | fetch_ready.
REQ-022 On response fire, SHALL load the output register next cycle with table[icache_rsp_tag] (tmask/pc/uuid), wid = icache_rsp_tag and instr = icache_rsp_data, and clear pending[icache_rsp_tag]; latency from response to fetch_valid is 1 cycle.
REQ-023 Output SHALL be held stable while fetch_valid & ~fetch_ready; fetch_valid SHALL clear after a fire with no new response.
REQ-024 On a simultaneous request fire and response fire (different wids), the outstanding count SHALL be unchanged and both pending updates SHALL apply.
REQ-025 A response fire with pending[tag]==0 SHALL set tag_error, leave the table unchanged and output no instruction; only reset clears tag_error.
REQ-026 The outstanding count SHALL neither wrap nor underflow; an underflowing response is covered by REQ-025.
REQ-027 SHALL drive busy = (outstanding != 0) | fetch_valid, registered one cycle.
REQ-028 A sched_valid for a wid whose pending bit is set SHALL stall (sched_ready=0) without dropping the request.

Reset
REQ-029 While reset is high: pending=0, outstanding=0, fetch_valid=0, tag_error=0, busy=0; table contents are don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight state; responses arriving after reset SHALL raise tag_error.

Verification
REQ-031 Single fetch: wid=2, pc=0x20000000, tmask=4'b0001, req_ready=1; rsp tag=2, data=0x00000013 two cycles later -> fetch_valid one cycle after the rsp with wid=2, pc=0x20000000, instr=0x13; busy drops afterwards.
REQ-032 Out-of-order: request wid0 then wid1, respond tag1 then tag0 -> outputs in response order, each carrying its own pc/tmask/uuid.
REQ-033 Credit limit: MAX_PENDING=2, three warps scheduled with no responses -> third request holds sched_ready=0 until one response fires, then it issues the following cycle.
REQ-034 Backpressure: fetch_ready=0 with output valid and a new rsp_valid -> icache_rsp_ready=0 and the output stays stable; releasing fetch_ready delivers both in order.
REQ-035 Same-warp block and error: re-schedule a pending wid -> sched_ready=0; rsp with tag=3 never requested -> tag_error=1 and stays 1 until reset.

Source files
------------

// File: rtl/vx_fetch.sv
// Instruction fetch: issues icache requests per warp and pairs out-of-order responses with their warp metadata.
// Request side is combinational; the fetch output is held in one register stage until decode accepts it.
module vx_fetch #(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int PC_BITS     = 30,
  parameter int UUID_WIDTH  = 1,
  parameter int MAX_PENDING = 4,
  localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [PC_BITS-1:0]     sched_pc,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,

  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [PC_BITS-1:0]     icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,

  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,

  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [PC_BITS-1:0]     fetch_pc,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic [31:0]            fetch_instr,

  output logic                   busy,
  output logic                   tag_error
);

  localparam int CNT_W    = $clog2(MAX_PENDING + 1);
  localparam int NW_DEPTH = 1 << NW_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NW_DEPTH-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic                   tag_error_q, tag_error_d;
  logic                   busy_q, busy_d;

  // Warp metadata table, tagged by wid; contents are don't-care until written.
  logic [NUM_THREADS-1:0] tbl_tmask_q [NW_DEPTH];
  logic [PC_BITS-1:0]     tbl_pc_q    [NW_DEPTH];
  logic [UUID_WIDTH-1:0]  tbl_uuid_q  [NW_DEPTH];

  logic [NW_WIDTH-1:0]    fetch_wid_q;
  logic [NUM_THREADS-1:0] fetch_tmask_q;
  logic [PC_BITS-1:0]     fetch_pc_q;
  logic [UUID_WIDTH-1:0]  fetch_uuid_q;
  logic [31:0]            fetch_instr_q;

  logic wid_free, credit_ok, req_fire, rsp_fire, rsp_hit, rsp_miss;

  assign wid_free         = ~pending_q[sched_wid];
  assign credit_ok        = (outstanding_q < CNT_MAX);
  assign icache_req_valid = sched_valid & wid_free & credit_ok;
  assign sched_ready      = icache_req_ready & wid_free & credit_ok;
  assign icache_req_addr  = sched_pc;
  assign icache_req_tag   = sched_wid;
  assign req_fire         = icache_req_valid & icache_req_ready;

  assign icache_rsp_ready = ~fetch_valid_q | fetch_ready;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
  // A response for a warp with nothing outstanding is a protocol error and is dropped.
  assign rsp_hit          = rsp_fire & pending_q[icache_rsp_tag];
  assign rsp_miss         = rsp_fire & ~pending_q[icache_rsp_tag];

  always_comb begin
    pending_d = pending_q;
    if (rsp_hit) begin
      pending_d[icache_rsp_tag] = 1'b0;
    end
    if (req_fire) begin
      pending_d[sched_wid] = 1'b1;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (req_fire && !rsp_hit && outstanding_q != CNT_MAX) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (rsp_hit && !req_fire && outstanding_q != '0) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end
  end

  always_comb begin
    fetch_valid_d = fetch_valid_q;
    if (rsp_hit) begin
      fetch_valid_d = 1'b1;
    end else if (fetch_ready) begin
      fetch_valid_d = 1'b0;
    end
    tag_error_d = tag_error_q | rsp_miss;
    busy_d      = (outstanding_q != '0) | fetch_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      fetch_valid_q <= 1'b0;
      tag_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      fetch_valid_q <= fetch_valid_d;
      tag_error_q   <= tag_error_d;
      busy_q        <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tbl_tmask_q[sched_wid] <= sched_tmask;
      tbl_pc_q[sched_wid]    <= sched_pc;
      tbl_uuid_q[sched_wid]  <= sched_uuid;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_hit) begin
      fetch_wid_q   <= icache_rsp_tag;
      fetch_tmask_q <= tbl_tmask_q[icache_rsp_tag];
      fetch_pc_q    <= tbl_pc_q[icache_rsp_tag];
      fetch_uuid_q  <= tbl_uuid_q[icache_rsp_tag];
      fetch_instr_q <= icache_rsp_data;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_wid   = fetch_wid_q;
  assign fetch_tmask = fetch_tmask_q;
  assign fetch_pc    = fetch_pc_q;
  assign fetch_uuid  = fetch_uuid_q;
  assign fetch_instr = fetch_instr_q;
  assign busy        = busy_q;
  assign tag_error   = tag_error_q;

endmodule

// File: tb/tb_vx_fetch.sv
// Bench for vx_fetch: directed scenarios plus random traffic, checked every cycle against a warp-set reference model.
module tb_vx_fetch;
  localparam int NW = 4, NT = 4, PCB = 30, UW = 1, MP = 2, WW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          sched_valid, sched_ready;
  logic [NT-1:0] sched_tmask;
  logic [PCB-1:0] sched_pc;
  logic [WW-1:0] sched_wid;
  logic [UW-1:0] sched_uuid;
  logic          icache_req_valid, icache_req_ready;
  logic [PCB-1:0] icache_req_addr;
  logic [WW-1:0] icache_req_tag;
  logic          icache_rsp_valid, icache_rsp_ready;
  logic [31:0]   icache_rsp_data;
  logic [WW-1:0] icache_rsp_tag;
  logic          fetch_valid, fetch_ready;
  logic [WW-1:0] fetch_wid;
  logic [NT-1:0] fetch_tmask;
  logic [PCB-1:0] fetch_pc;
  logic [UW-1:0] fetch_uuid;
  logic [31:0]   fetch_instr;
  logic          busy, tag_error;

  vx_fetch #(.NUM_WARPS(NW), .NUM_THREADS(NT), .PC_BITS(PCB), .UUID_WIDTH(UW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_tmask(sched_tmask),
    .sched_pc(sched_pc), .sched_wid(sched_wid), .sched_uuid(sched_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_wid(fetch_wid),
    .fetch_tmask(fetch_tmask), .fetch_pc(fetch_pc), .fetch_uuid(fetch_uuid),
    .fetch_instr(fetch_instr), .busy(busy), .tag_error(tag_error)
  );

  int npass = 0, ntot = 0, nfail = 0;

  // Reference model: the set of warps awaiting an instruction, their metadata, and the output slot.
  bit             m_pend [NW];
  logic [NT-1:0]  m_tmask [NW];
  logic [PCB-1:0] m_pc [NW];
  logic [UW-1:0]  m_uuid [NW];
  bit             m_ovalid = 0, m_err = 0, m_busy = 0;
  logic [WW-1:0]  m_owid;
  logic [NT-1:0]  m_otmask;
  logic [PCB-1:0] m_opc;
  logic [UW-1:0]  m_ouuid;
  logic [31:0]    m_oinstr;

  int             got_wid [$];
  logic [PCB-1:0] got_pc [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int inflight();
    int n = 0;
    for (int w = 0; w < NW; w++) n += m_pend[w] ? 1 : 0;
    return n;
  endfunction

  function automatic bit can_issue();
    return !m_pend[sched_wid] && (inflight() < MP);
  endfunction

  task automatic check_outputs();
    bit c;
    c = can_issue();
    chk("req_valid", icache_req_valid, sched_valid & c);
    chk("sched_ready", sched_ready, icache_req_ready & c);
    chk("req_addr", icache_req_addr, sched_pc);
    chk("req_tag", icache_req_tag, sched_wid);
    chk("rsp_ready", icache_rsp_ready, !m_ovalid | fetch_ready);
    chk("fetch_valid", fetch_valid, m_ovalid);
    if (m_ovalid) begin
      chk("fetch_wid", fetch_wid, m_owid);
      chk("fetch_tmask", fetch_tmask, m_otmask);
      chk("fetch_pc", fetch_pc, m_opc);
      chk("fetch_uuid", fetch_uuid, m_ouuid);
      chk("fetch_instr", fetch_instr, m_oinstr);
    end
    chk("busy", busy, m_busy);
    chk("tag_error", tag_error, m_err);
  endtask

  task automatic model_step();
    bit req_fire, rsp_fire, next_busy;
    if (reset) begin
      for (int w = 0; w < NW; w++) m_pend[w] = 0;
      m_ovalid = 0; m_err = 0; m_busy = 0;
      return;
    end
    next_busy = (inflight() != 0) || m_ovalid;
    req_fire  = sched_valid && icache_req_ready && can_issue();
    rsp_fire  = icache_rsp_valid && (!m_ovalid || fetch_ready);
    if (fetch_ready) m_ovalid = 0;
    if (rsp_fire) begin
      if (m_pend[icache_rsp_tag]) begin
        m_ovalid = 1;
        m_owid   = icache_rsp_tag;
        m_otmask = m_tmask[icache_rsp_tag];
        m_opc    = m_pc[icache_rsp_tag];
        m_ouuid  = m_uuid[icache_rsp_tag];
        m_oinstr = icache_rsp_data;
        m_pend[icache_rsp_tag] = 0;
      end else begin
        m_err = 1;
      end
    end
    if (req_fire) begin
      m_pend[sched_wid]  = 1;
      m_tmask[sched_wid] = sched_tmask;
      m_pc[sched_wid]    = sched_pc;
      m_uuid[sched_wid]  = sched_uuid;
    end
    m_busy = next_busy;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    if (fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
      got_wid.push_back(int'(fetch_wid));
      got_pc.push_back(fetch_pc);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input bit v, input int wid, input logic [PCB-1:0] pc, input logic [NT-1:0] tm, input logic [UW-1:0] uu);
    sched_valid = v; sched_wid = WW'(wid); sched_pc = pc; sched_tmask = tm; sched_uuid = uu;
  endtask

  task automatic rsp(input bit v, input int tag, input logic [31:0] data);
    icache_rsp_valid = v; icache_rsp_tag = WW'(tag); icache_rsp_data = data;
  endtask

  initial begin
    sched(0, 0, '0, '0, '0);
    rsp(0, 0, '0);
    icache_req_ready = 1'b1;
    fetch_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);

    // Single fetch on warp 2
    sched(1, 2, 30'h20000000, 4'b0001, 1'b1);
    tick();
    sched(0, 0, '0, '0, '0);
    tick();
    rsp(1, 2, 32'h00000013);
    tick();
    rsp(0, 0, '0);
    chk("single_valid", fetch_valid, 1'b1);
    chk("single_wid", fetch_wid, 2'd2);
    chk("single_pc", fetch_pc, 30'h20000000);
    chk("single_instr", fetch_instr, 32'h13);
    repeat (3) tick();
    chk("single_busy_drop", busy, 1'b0);

    // Out-of-order responses
    got_wid.delete(); got_pc.delete();
    sched(1, 0, 30'h00000100, 4'b1111, 1'b0);
    tick();
    sched(1, 1, 30'h00000200, 4'b0110, 1'b1);
    tick();
    sched(0, 0, '0, '0, '0);
    rsp(1, 1, 32'hAAAA0001);
    tick();
    chk("ooo_first_wid", fetch_wid, 2'd1);
    chk("ooo_first_pc", fetch_pc, 30'h200);
    chk("ooo_first_tmask", fetch_tmask, 4'b0110);
    rsp(1, 0, 32'hBBBB0000);
    tick();
    rsp(0, 0, '0);
    chk("ooo_second_wid", fetch_wid, 2'd0);
    chk("ooo_second_pc", fetch_pc, 30'h100);
    chk("ooo_second_instr", fetch_instr, 32'hBBBB0000);
    repeat (2) tick();
    chk("ooo_count", got_wid.size(), 2);

    // Credit limit of two outstanding requests
    sched(1, 0, 30'h300, 4'b0001, 1'b0);
    tick();
    sched(1, 1, 30'h304, 4'b0010, 1'b0);
    tick();
    sched(1, 2, 30'h308, 4'b0100, 1'b1);
    #1;
    chk("credit_stall", sched_ready, 1'b0);
    repeat (2) tick();
    rsp(1, 0, 32'h11);
    #1;
    chk("credit_stall_rsp", sched_ready, 1'b0);
    tick();
    rsp(0, 0, '0);
    chk("credit_release_rdy", sched_ready, 1'b1);
    chk("credit_release_vld", icache_req_valid, 1'b1);
    tick();
    sched(0, 0, '0, '0, '0);
    rsp(1, 1, 32'h22);
    tick();
    rsp(1, 2, 32'h33);
    tick();
    rsp(0, 0, '0);
    chk("credit_third_pc", fetch_pc, 30'h308);
    repeat (2) tick();

    // Output backpressure
    got_wid.delete(); got_pc.delete();
    sched(1, 0, 30'h400, 4'b1000, 1'b0);
    tick();
    sched(1, 1, 30'h404, 4'b0100, 1'b1);
    tick();
    sched(0, 0, '0, '0, '0);
    fetch_ready = 1'b0;
    rsp(1, 0, 32'hC0);
    tick();
    rsp(1, 1, 32'hC1);
    #1;
    chk("bp_rsp_ready", icache_rsp_ready, 1'b0);
    repeat (2) tick();
    chk("bp_hold_wid", fetch_wid, 2'd0);
    chk("bp_hold_instr", fetch_instr, 32'hC0);
    fetch_ready = 1'b1;
    #1;
    chk("bp_release_rdy", icache_rsp_ready, 1'b1);
    tick();
    rsp(0, 0, '0);
    tick();
    tick();
    chk("bp_count", got_wid.size(), 2);
    if (got_wid.size() == 2) begin
      chk("bp_order0", got_wid[0], 0);
      chk("bp_order1", got_wid[1], 1);
    end

    // Same-warp block and stray tag
    sched(1, 1, 30'h500, 4'b0001, 1'b0);
    tick();
    #1;
    chk("same_warp_ready", sched_ready, 1'b0);
    chk("same_warp_valid", icache_req_valid, 1'b0);
    tick();
    sched(0, 0, '0, '0, '0);
    rsp(1, 3, 32'hDEAD);
    tick();
    rsp(0, 0, '0);
    chk("stray_err", tag_error, 1'b1);
    chk("stray_no_out", fetch_valid, 1'b0);
    rsp(1, 1, 32'h55);
    tick();
    rsp(0, 0, '0);
    repeat (2) tick();
    chk("stray_sticky", tag_error, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stray_cleared", tag_error, 1'b0);

    // Reset with a request in flight
    sched(1, 0, 30'h600, 4'b0011, 1'b0);
    tick();
    sched(0, 0, '0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    rsp(1, 0, 32'h66);
    tick();
    rsp(0, 0, '0);
    chk("midrst_err", tag_error, 1'b1);
    chk("midrst_no_out", fetch_valid, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int w;
      sched($urandom_range(0, 1) == 1, $urandom_range(0, NW - 1), PCB'($urandom),
            NT'($urandom), UW'($urandom));
      icache_req_ready = ($urandom_range(0, 3) != 0);
      fetch_ready = ($urandom_range(0, 9) < 7);
      w = $urandom_range(0, NW - 1);
      rsp((m_pend[w] && $urandom_range(0, 1) == 1) || $urandom_range(0, 60) == 0, w, $urandom);
      tick();
    end
    sched(0, 0, '0, '0, '0);
    rsp(0, 0, '0);
    fetch_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
